// File: rtl/usb_tx_pkg.sv
// Shared definitions for the USB full-speed NRZI transmitter.
//   SYNC_BYTE   : byte sent ahead of every packet (LSB first)
//   LS_*        : line states encoded as {d_plus, d_minus}
//   tx_state_t  : transmit FSM states
package usb_tx_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'h80;

  localparam logic [1:0] LS_J   = 2'b10;
  localparam logic [1:0] LS_K   = 2'b01;
  localparam logic [1:0] LS_SE0 = 2'b00;

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    STUFF,
    EOP_SE0,
    EOP_J
  } tx_state_t;

endpackage

// File: rtl/usb_tx_bit_timer.sv
// USB bit-time generator.
// Counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit time.
//   clk      : system clock
//   n_rst    : asynchronous active-low reset
//   clear    : hold the counter at 0 (used while the transmitter is idle)
//   bit_tick : high in the final cycle of a bit time
module usb_tx_bit_timer #(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic clk,
  input  logic n_rst,
  input  logic clear,
  output logic bit_tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] TC = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_cnt <= '0;
    end else if (clear || (r_cnt == TC)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign bit_tick = (r_cnt == TC) && !clear;

endmodule

// File: rtl/usb_nrzi_tx.sv
// USB full-speed transmit line driver.
// Prepends SYNC, serializes bytes LSB first, bit-stuffs after STUFF_LEN ones,
// NRZI-encodes onto D+/D- and closes each packet with SE0/SE0/J.
//   clk, n_rst          : clock, asynchronous active-low reset
//   tx_valid/tx_data/tx_last/tx_ready : byte handshake from the packet layer
//   d_plus, d_minus     : registered pad drive
//   tx_active           : output enable, SYNC through EOP J
//   tx_done             : 1-cycle pulse after the EOP J bit
//   tx_err              : 1-cycle pulse when the byte stream underruns
//
// state   | meaning
// IDLE    | line J, waiting for the first byte
// SEND    | driving a SYNC/data bit
// STUFF   | driving an inserted stuff 0
// EOP_SE0 | driving SE0 for EOP_SE0_BITS bit times
// EOP_J   | driving the closing J bit
module usb_nrzi_tx
  import usb_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 8,
  parameter int STUFF_LEN    = 6,
  parameter int EOP_SE0_BITS = 2
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       d_plus,
  output logic       d_minus,
  output logic       tx_active,
  output logic       tx_done,
  output logic       tx_err
);

  localparam int OW = $clog2(STUFF_LEN + 1);
  localparam logic [OW-1:0] STUFF_CNT = OW'(STUFF_LEN);
  localparam logic [2:0]    SE0_LAST  = 3'(EOP_SE0_BITS - 1);

  tx_state_t r_state, w_state_nxt;
  logic [7:0]    r_shift, w_shift_nxt;
  logic [2:0]    r_bit_idx, w_idx_nxt;
  logic [OW-1:0] r_ones, w_ones_nxt;
  logic [7:0]    r_hold_data, w_hold_data_nxt;
  logic          r_hold_last, w_hold_last_nxt;
  logic          r_hold_full, w_hold_full_nxt;
  logic          r_cur_last, w_cur_last_nxt;
  logic [1:0]    r_line, w_line_nxt;
  logic          r_active, w_active_nxt;
  logic          r_ready, w_ready_nxt;
  logic          r_done, w_done_nxt;
  logic          r_err, w_err_nxt;

  logic       w_bit_tick;
  logic       w_accept;
  logic       w_drive;
  logic       w_bit;
  logic       w_adv;
  logic [2:0] w_idx_inc;
  logic [7:0] w_next_byte;
  logic       w_next_last;

  usb_tx_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk     (clk),
    .n_rst   (n_rst),
    .clear   (r_state == IDLE),
    .bit_tick(w_bit_tick)
  );

  assign w_accept  = tx_valid && r_ready;
  assign w_idx_inc = r_bit_idx + 3'd1;

  // A byte accepted on the very edge a byte ends goes straight to the shifter,
  // so a just-in-time producer never triggers a false underrun.
  assign w_next_byte = r_hold_full ? r_hold_data : tx_data;
  assign w_next_last = r_hold_full ? r_hold_last : tx_last;

  always_comb begin
    w_state_nxt     = r_state;
    w_shift_nxt     = r_shift;
    w_idx_nxt       = r_bit_idx;
    w_ones_nxt      = r_ones;
    w_hold_data_nxt = r_hold_data;
    w_hold_last_nxt = r_hold_last;
    w_hold_full_nxt = r_hold_full;
    w_cur_last_nxt  = r_cur_last;
    w_line_nxt      = r_line;
    w_active_nxt    = r_active;
    w_done_nxt      = 1'b0;
    w_err_nxt       = 1'b0;
    w_drive         = 1'b0;
    w_bit           = 1'b0;
    w_adv           = 1'b0;

    if (w_accept) begin
      w_hold_data_nxt = tx_data;
      w_hold_last_nxt = tx_last;
      w_hold_full_nxt = 1'b1;
    end

    case (r_state)
      IDLE: begin
        w_line_nxt   = LS_J;
        w_ones_nxt   = '0;
        w_active_nxt = 1'b0;
        if (w_accept) begin
          w_shift_nxt    = SYNC_BYTE;
          w_idx_nxt      = 3'd0;
          w_cur_last_nxt = 1'b0;
          w_drive        = 1'b1;
          w_bit          = SYNC_BYTE[0];
          w_active_nxt   = 1'b1;
          w_state_nxt    = SEND;
        end
      end
      SEND: begin
        if (w_bit_tick) begin
          if (r_ones == STUFF_CNT) begin
            w_drive     = 1'b1;
            w_bit       = 1'b0;
            w_state_nxt = STUFF;
          end else begin
            w_adv = 1'b1;
          end
        end
      end
      STUFF: begin
        if (w_bit_tick) begin
          w_adv       = 1'b1;
          w_state_nxt = SEND;
        end
      end
      EOP_SE0: begin
        if (w_bit_tick) begin
          if (r_bit_idx == SE0_LAST) begin
            w_line_nxt  = LS_J;
            w_state_nxt = EOP_J;
          end else begin
            w_idx_nxt = w_idx_inc;
          end
        end
      end
      EOP_J: begin
        if (w_bit_tick) begin
          w_active_nxt = 1'b0;
          w_done_nxt   = 1'b1;
          w_ones_nxt   = '0;
          w_state_nxt  = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    // Step to the next data bit, the next byte, or the end of packet.
    if (w_adv) begin
      if (r_bit_idx != 3'd7) begin
        w_idx_nxt   = w_idx_inc;
        w_drive     = 1'b1;
        w_bit       = r_shift[w_idx_inc];
        w_state_nxt = SEND;
      end else if (r_hold_full || w_accept) begin
        w_shift_nxt     = w_next_byte;
        w_cur_last_nxt  = w_next_last;
        w_hold_full_nxt = 1'b0;
        w_idx_nxt       = 3'd0;
        w_drive         = 1'b1;
        w_bit           = w_next_byte[0];
        w_state_nxt     = SEND;
      end else begin
        w_err_nxt   = !r_cur_last;
        w_line_nxt  = LS_SE0;
        w_idx_nxt   = 3'd0;
        w_ones_nxt  = '0;
        w_state_nxt = EOP_SE0;
      end
    end

    // NRZI: a 0 flips J<->K, a 1 holds the line.
    if (w_drive) begin
      w_line_nxt = w_bit ? r_line : ~r_line;
      w_ones_nxt = w_bit ? (r_ones + 1'b1) : '0;
    end
  end

  assign w_ready_nxt = !w_hold_full_nxt && (w_state_nxt != EOP_SE0) && (w_state_nxt != EOP_J);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state     <= IDLE;
      r_shift     <= '0;
      r_bit_idx   <= '0;
      r_ones      <= '0;
      r_hold_data <= '0;
      r_hold_last <= 1'b0;
      r_hold_full <= 1'b0;
      r_cur_last  <= 1'b0;
      r_line      <= LS_J;
      r_active    <= 1'b0;
      r_ready     <= 1'b1;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_shift     <= w_shift_nxt;
      r_bit_idx   <= w_idx_nxt;
      r_ones      <= w_ones_nxt;
      r_hold_data <= w_hold_data_nxt;
      r_hold_last <= w_hold_last_nxt;
      r_hold_full <= w_hold_full_nxt;
      r_cur_last  <= w_cur_last_nxt;
      r_line      <= w_line_nxt;
      r_active    <= w_active_nxt;
      r_ready     <= w_ready_nxt;
      r_done      <= w_done_nxt;
      r_err       <= w_err_nxt;
    end
  end

  assign d_plus    = r_line[1];
  assign d_minus   = r_line[0];
  assign tx_active = r_active;
  assign tx_ready  = r_ready;
  assign tx_done   = r_done;
  assign tx_err    = r_err;

endmodule

// File: tb/tb_usb_nrzi_tx.sv
module tb_usb_nrzi_tx;

  localparam int CPB = 8;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_last;
  logic       tx_ready;
  logic       d_plus;
  logic       d_minus;
  logic       tx_active;
  logic       tx_done;
  logic       tx_err;

  always #5 clk = ~clk;

  usb_nrzi_tx #(
    .CLKS_PER_BIT(CPB),
    .STUFF_LEN   (6),
    .EOP_SE0_BITS(2)
  ) dut (
    .clk      (clk),
    .n_rst    (n_rst),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_last  (tx_last),
    .tx_ready (tx_ready),
    .d_plus   (d_plus),
    .d_minus  (d_minus),
    .tx_active(tx_active),
    .tx_done  (tx_done),
    .tx_err   (tx_err)
  );

  typedef struct {
    string      name;
    int         n;
    logic [7:0] b0;
    logic [7:0] b1;
    logic [7:0] b2;
    bit         underrun;
    int         exp_bits;   // bit times from first K to end of EOP J
  } vec_t;

  int n_pass  = 0;
  int n_total = 0;

  logic [1:0] ref_lv[$];
  logic [1:0] mon_line[$];
  logic       mon_ready[$];
  int         mon_err_cyc[$];
  logic       mon_done_end;
  logic       mon_done_after;
  int         mon_done_early;

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  // Reference encoder: SYNC + bytes LSB first, a stuff 0 after every six
  // consecutive ones, NRZI from J, then SE0 SE0 J. One entry per bit time.
  function automatic void build_ref(input logic [7:0] bytes[$]);
    logic [7:0] all[$];
    logic [1:0] lvl;
    int ones;
    ref_lv.delete();
    all.push_back(8'h80);
    foreach (bytes[i]) all.push_back(bytes[i]);
    lvl  = 2'b10;
    ones = 0;
    foreach (all[i]) begin
      for (int b = 0; b < 8; b++) begin
        if (all[i][b]) ones++;
        else begin
          ones = 0;
          lvl  = (lvl == 2'b10) ? 2'b01 : 2'b10;
        end
        ref_lv.push_back(lvl);
        if (ones == 6) begin
          ones = 0;
          lvl  = (lvl == 2'b10) ? 2'b01 : 2'b10;
          ref_lv.push_back(lvl);
        end
      end
    end
    ref_lv.push_back(2'b00);
    ref_lv.push_back(2'b00);
    ref_lv.push_back(2'b10);
  endfunction

  task automatic drive(input logic [7:0] bytes[$], input bit underrun);
    int t;
    for (int i = 0; i < bytes.size(); i++) begin
      @(negedge clk);
      tx_valid = 1'b1;
      tx_data  = bytes[i];
      tx_last  = (i == bytes.size() - 1) && !underrun;
      t = 0;
      while (!tx_ready && t < 3000) begin
        @(negedge clk);
        t++;
      end
      if (!tx_ready) begin
        chk("accept_timeout", 0, 1);
        break;
      end
      @(posedge clk);
    end
    @(negedge clk);
    tx_valid = 1'b0;
    tx_last  = 1'($urandom);
    tx_data  = 8'($urandom);
  endtask

  task automatic monitor();
    int t;
    mon_line.delete();
    mon_ready.delete();
    mon_err_cyc.delete();
    mon_done_early = 0;
    t = 0;
    while (!tx_active && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (!tx_active) begin
      chk("active_start_timeout", 0, 1);
      mon_done_end   = 1'b0;
      mon_done_after = 1'b0;
      return;
    end
    t = 0;
    while (tx_active && t < 3000) begin
      mon_line.push_back({d_plus, d_minus});
      mon_ready.push_back(tx_ready);
      if (tx_err) mon_err_cyc.push_back(t);
      if (tx_done) mon_done_early++;
      @(negedge clk);
      t++;
    end
    mon_done_end = tx_done;
    @(negedge clk);
    mon_done_after = tx_done;
  endtask

  task automatic run_packet(input string nm, input logic [7:0] bytes[$],
                            input bit underrun, input int exp_bits);
    int got;
    int bad;
    build_ref(bytes);
    fork
      drive(bytes, underrun);
      monitor();
    join
    if (exp_bits > 0) chk({nm, "_active_cycles"}, mon_line.size(), exp_bits * CPB);
    chk({nm, "_model_len"}, mon_line.size(), ref_lv.size() * CPB);
    for (int b = 0; b < ref_lv.size(); b++) begin
      if ((b + 1) * CPB > mon_line.size()) got = -1;
      else begin
        bad = -1;
        for (int c = 0; c < CPB; c++)
          if (mon_line[b*CPB+c] !== ref_lv[b] && bad < 0) bad = b * CPB + c;
        got = (bad < 0) ? int'(mon_line[b*CPB]) : int'(mon_line[bad]);
      end
      chk($sformatf("%s_line_bit%0d", nm, b), got, int'(ref_lv[b]));
    end
    chk({nm, "_err_count"}, mon_err_cyc.size(), underrun ? 1 : 0);
    if (underrun && mon_err_cyc.size() == 1)
      chk({nm, "_err_cycle"}, mon_err_cyc[0], (ref_lv.size() - 3) * CPB);
    chk({nm, "_done_early"}, mon_done_early, 0);
    chk({nm, "_done_pulse"}, int'(mon_done_end), 1);
    chk({nm, "_done_width"}, int'(mon_done_after), 0);
    chk({nm, "_idle_line"}, int'({d_plus, d_minus}), 2);
  endtask

  vec_t vecs[5];
  logic [7:0] pkt[$];
  int t;

  initial begin
    vecs[0] = '{"b00",     1, 8'h00, 8'h00, 8'h00, 1'b0, 19};
    vecs[1] = '{"bFF",     1, 8'hFF, 8'h00, 8'h00, 1'b0, 20};
    vecs[2] = '{"three",   3, 8'h12, 8'h34, 8'h56, 1'b0, 35};
    vecs[3] = '{"underrun",1, 8'hA5, 8'h00, 8'h00, 1'b1, 19};
    vecs[4] = '{"b3F",     1, 8'h3F, 8'h00, 8'h00, 1'b0, 20};

    n_rst    = 1'b1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    tx_last  = 1'b0;
    #2 n_rst = 1'b0;
    #3;
    chk("rst_d_plus",    int'(d_plus),    1);
    chk("rst_d_minus",   int'(d_minus),   0);
    chk("rst_tx_active", int'(tx_active), 0);
    chk("rst_tx_ready",  int'(tx_ready),  1);
    chk("rst_tx_done",   int'(tx_done),   0);
    chk("rst_tx_err",    int'(tx_err),    0);
    repeat (3) @(negedge clk);
    n_rst = 1'b1;
    repeat (3) @(negedge clk);

    foreach (vecs[i]) begin
      pkt.delete();
      pkt.push_back(vecs[i].b0);
      if (vecs[i].n > 1) pkt.push_back(vecs[i].b1);
      if (vecs[i].n > 2) pkt.push_back(vecs[i].b2);
      run_packet(vecs[i].name, pkt, vecs[i].underrun, vecs[i].exp_bits);
      if (vecs[i].n == 3 && mon_ready.size() > 256) begin
        chk("three_ready_c0",   int'(mon_ready[0]),   0);
        chk("three_ready_c63",  int'(mon_ready[63]),  0);
        chk("three_ready_c64",  int'(mon_ready[64]),  1);
        chk("three_ready_c65",  int'(mon_ready[65]),  0);
        chk("three_ready_c127", int'(mon_ready[127]), 0);
        chk("three_ready_c128", int'(mon_ready[128]), 1);
        chk("three_ready_c129", int'(mon_ready[129]), 0);
        chk("three_ready_c192", int'(mon_ready[192]), 1);
        chk("three_ready_c193", int'(mon_ready[193]), 1);
        chk("three_ready_eop",  int'(mon_ready[256]), 0);
      end
      repeat (4) @(negedge clk);
    end

    // Reset in the middle of the second data byte.
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = 8'hC3;
    tx_last  = 1'b0;
    @(posedge clk);
    @(negedge clk);
    tx_data = 8'h5A;
    t = 0;
    while (!tx_ready && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk("rst_mid_second_accept", int'(tx_ready), 1);
    @(posedge clk);
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (85) @(negedge clk);
    chk("rst_mid_active_before", int'(tx_active), 1);
    #2 n_rst = 1'b0;
    #1;
    chk("rst_mid_d_plus",    int'(d_plus),    1);
    chk("rst_mid_d_minus",   int'(d_minus),   0);
    chk("rst_mid_tx_active", int'(tx_active), 0);
    chk("rst_mid_tx_ready",  int'(tx_ready),  1);
    chk("rst_mid_tx_err",    int'(tx_err),    0);
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    repeat (2) @(negedge clk);
    pkt.delete();
    pkt.push_back(8'hA5);
    pkt.push_back(8'h3C);
    run_packet("post_rst", pkt, 1'b0, 27);
    repeat (3) @(negedge clk);

    for (int r = 0; r < 20; r++) begin
      int nb;
      bit ur;
      pkt.delete();
      nb = $urandom_range(1, 3);
      for (int k = 0; k < nb; k++)
        pkt.push_back(($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom));
      ur = ($urandom_range(0, 4) == 0);
      run_packet($sformatf("rnd%0d", r), pkt, ur, 0);
      repeat ($urandom_range(1, 5)) @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
